seq_alu: RTL and testbench

//  Parametrised, registered ALU with a valid/ready handshake on input and output.

---
 rtl/seq_alu_if.sv | 34 +++
 rtl/seq_alu.sv | 177 +++++++++++++++++
 tb/tb_seq_alu.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between a controller and seq_alu.
//
// Request channel (controller -> ALU):
//   in_valid, opcode[2:0], operand1[WIDTH-1:0], operand2[WIDTH-1:0]; in_ready flows back.
// Response channel (ALU -> controller):
//   out_valid, result[WIDTH-1:0], result_hi[WIDTH-1:0], carry, zero, err; out_ready flows back.
//
// Modports: master = controller side, slave = ALU side.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, opcode, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, zero, err
  );

  modport slave (
    input  in_valid, opcode, operand1, operand2, out_ready,
    output in_ready, out_valid, result, result_hi, carry, zero, err
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on request and response.
//
// Operations (opcode): 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110/111 illegal.
// Add/sub/logic ops and illegal opcodes complete on the accept edge. Mul is an unsigned
// shift-add taking one iteration per clock for WIDTH clocks. One operation in flight.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_if.slave (request: in_valid/in_ready/opcode/operand1/operand2;
//          response: out_valid/out_ready/result/result_hi/carry/zero/err)
//
// Build option: define SEQ_ALU_MUL_EN to include the multiplier. Without it, opcode 101 is
// reported as illegal and result_hi is tied to zero.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  seq_alu_if.slave   bus
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [2:0]  OpMul = 3'b101;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             err_q;

  // Single-cycle datapath, evaluated on the live request so it can be registered at accept.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_err;

  always_comb begin
    sum_w     = {1'b0, bus.operand1} + {1'b0, bus.operand2};
    // Bit WIDTH of the widened difference is the borrow (operand1 < operand2).
    diff_w    = {1'b0, bus.operand1} - {1'b0, bus.operand2};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (bus.opcode)
      OpAdd: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OpSub: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
      end
      OpAnd:   alu_res = bus.operand1 & bus.operand2;
      OpOr:    alu_res = bus.operand1 | bus.operand2;
      OpXor:   alu_res = bus.operand1 ^ bus.operand2;
      // Mul never takes this path when enabled; otherwise 101 lands here as illegal.
      default: alu_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0]   result_hi_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [CntW-1:0]    count_q;
  logic [CntW-1:0]    count_next;
  logic               is_mul;

  assign is_mul = (bus.opcode == OpMul);

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    count_next = count_q + CntW'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      result_hi_q <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
`ifdef SEQ_ALU_MUL_EN
            if (is_mul) begin
              mcand_q  <= {{WIDTH{1'b0}}, bus.operand1};
              mplier_q <= bus.operand2;
              acc_q    <= '0;
              count_q  <= '0;
              state_q  <= StMul;
            end else
`endif
            begin
              result_q    <= alu_res;
              carry_q     <= alu_carry;
              zero_q      <= (alu_res == '0);
              err_q       <= alu_err;
`ifdef SEQ_ALU_MUL_EN
              result_hi_q <= '0;
`endif
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
`ifdef SEQ_ALU_MUL_EN
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_next;
          // Last iteration: publish the product on this same edge.
          if (count_next == CntW'(WIDTH)) begin
            result_q    <= acc_next[WIDTH-1:0];
            result_hi_q <= acc_next[2*WIDTH-1:WIDTH];
            carry_q     <= |acc_next[2*WIDTH-1:WIDTH];
            zero_q      <= (acc_next == '0);
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
`endif
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
`ifdef SEQ_ALU_MUL_EN
  assign bus.result_hi = result_hi_q;
`else
  assign bus.result_hi = '0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_seq_alu;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge, then scramble the operands.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.operand1 = a;
    bus.operand2 = b;
    step();
    bus.in_valid = 1'b0;
    bus.opcode   = 3'b000;
    bus.operand1 = 8'h00;
    bus.operand2 = 8'h00;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                            input logic cy, input logic zr, input logic er);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.result), 32'(res));
    chk({tag, "_result_hi"}, 32'(bus.result_hi), 32'(hi));
    chk({tag, "_carry"}, 32'(bus.carry), 32'(cy));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(zr));
    chk({tag, "_err"}, 32'(bus.err), 32'(er));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 3'b000;
    bus.operand1  = 8'h00;
    bus.operand2  = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_result_hi", 32'(bus.result_hi), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // add 200+100 = 300 -> 44 with carry
    issue(3'b000, 8'd200, 8'd100);
    expect_out("add", 8'd44, 8'd0, 1'b1, 1'b0, 1'b0);
    drain("add");

    // sub wraps with borrow; equal operands give zero
    issue(3'b001, 8'd5, 8'd7);
    expect_out("sub_wrap", 8'd254, 8'd0, 1'b1, 1'b0, 1'b0);
    drain("sub_wrap");
    issue(3'b001, 8'd7, 8'd7);
    expect_out("sub_zero", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    drain("sub_zero");

    issue(3'b011, 8'hA0, 8'h05);
    expect_out("or", 8'hA5, 8'd0, 1'b0, 1'b0, 1'b0);
    drain("or");

`ifdef SEQ_ALU_MUL_EN
    // 255*255 = 0xFE01, valid exactly 8 edges after accept
    issue(3'b101, 8'd255, 8'd255);
    for (int i = 1; i < 8; i++) begin
      chk("mul_busy_valid", 32'(bus.out_valid), 32'd0);
      chk("mul_busy_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    chk("mul_edge7_valid", 32'(bus.out_valid), 32'd0);
    step();
    expect_out("mul", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0);
    drain("mul");
`else
    // Without the multiplier, 101 is an illegal opcode with single-cycle latency
    issue(3'b101, 8'd3, 8'd4);
    expect_out("mul_illegal", 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    drain("mul_illegal");
`endif

    // Backpressure: result held, new request ignored
    issue(3'b100, 8'hF0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.opcode   = 3'b000;
      bus.operand1 = 8'd1;
      bus.operand2 = 8'd1;
      expect_out("xor_hold", 8'hCC, 8'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    expect_out("xor_hold_end", 8'hCC, 8'd0, 1'b0, 1'b0, 1'b0);
    drain("xor");
    step();
    chk("xor_no_stray_valid", 32'(bus.out_valid), 32'd0);

    // Illegal opcodes
    issue(3'b110, 8'd9, 8'd9);
    expect_out("op110", 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    drain("op110");
    issue(3'b111, 8'd1, 8'd2);
    expect_out("op111", 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    drain("op111");

    // Leave a nonzero result so a reset-cleared result is distinguishable
    issue(3'b000, 8'd1, 8'd2);
    expect_out("pre_rst", 8'd3, 8'd0, 1'b0, 1'b0, 1'b0);
    drain("pre_rst");

`ifdef SEQ_ALU_MUL_EN
    // Reset during the 3rd clock of a multiply
    issue(3'b101, 8'd255, 8'd255);
    step();
    step();
    rst_n = 1'b0;
`else
    // Reset while a result is waiting
    issue(3'b000, 8'd1, 8'd2);
    rst_n = 1'b0;
`endif
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_carry", 32'(bus.carry), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("postrst_no_valid", 32'(bus.out_valid), 32'd0);
      step();
    end

    issue(3'b010, 8'h0F, 8'hFF);
    expect_out("and", 8'h0F, 8'd0, 1'b0, 1'b0, 1'b0);
    drain("and");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
